serial_addsub: RTL and testbench

Multi-cycle adder/subtractor for N-bit operands, naturals or two's-complement integers, processing K bits per clock with a soc/eoc handshake. It produces both carry/borrow and overflow, and the user connects whichever applies. It replaces a wide combinational add/diff when the datapath is shared or timing-limited. The op input selects add or subtract at run time.

---
 rtl/serial_addsub_if.sv | 25 ++
 rtl/serial_addsub.sv | 141 ++++++++++++++
 tb/tb_serial_addsub.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/serial_addsub_if.sv
// Operand/result bundle and soc/eoc handshake for the serial adder/subtractor.
// The master side starts operations; the slave side is the arithmetic block.
interface serial_addsub_if #(
  parameter int N = 8
) ();
  logic         soc;
  logic         op;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         c_in;
  logic [N-1:0] s;
  logic         c_out;
  logic         ow;
  logic         eoc;

  modport master (
    output soc, op, x, y, c_in,
    input  s, c_out, ow, eoc
  );

  modport slave (
    input  soc, op, x, y, c_in,
    output s, c_out, ow, eoc
  );
endinterface

// File: rtl/serial_addsub.sv
// Multi-cycle N-bit add/subtract working K bits per clock, with registered
// sum/difference, carry/borrow and two's-complement overflow outputs.
module serial_addsub #(
  parameter int N = 8,
  parameter int K = 2
) (
  input logic           clock,
  input logic           reset_,
  serial_addsub_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for soc, eoc = 1
  // RUN   | one K-bit slice per clock, eoc = 0
  // DONE  | result valid, waiting for soc to drop, eoc = 1

  localparam int SLICES = (K >= 1) ? (N / K) : 1;
  localparam int CW     = (SLICES > 1) ? $clog2(SLICES) : 1;

  generate
    if (K < 1) begin : g_bad_k
      $error("serial_addsub: K must be at least 1");
    end else if ((N % K) != 0) begin : g_bad_nk
      $error("serial_addsub: N must be a multiple of K");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  x_q, x_d;
  logic [N-1:0]  y_q, y_d;
  logic          op_q, op_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  s_q, s_d;
  logic          c_out_q, c_out_d;
  logic          ow_q, ow_d;

  int            base;
  logic [K-1:0]  xs;
  logic [K-1:0]  ys;
  logic [K:0]    slice_sum;
  logic [N-1:0]  acc_upd;

  always_comb begin
    base      = int'(cnt_q) * K;
    xs        = x_q[base +: K];
    ys        = y_q[base +: K];
    // Subtract is x + ~y + 1 with the borrow-in folded into the initial carry.
    slice_sum = {1'b0, xs} + {1'b0, (op_q ? ~ys : ys)} + {{K{1'b0}}, carry_q};
    acc_upd   = acc_q;
    acc_upd[base +: K] = slice_sum[K-1:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    s_d     = s_q;
    c_out_d = c_out_q;
    ow_d    = ow_q;

    case (state_q)
      IDLE: begin
        if (bus.soc) begin
          x_d     = bus.x;
          y_d     = bus.y;
          op_d    = bus.op;
          carry_d = bus.c_in ^ bus.op;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_upd;
        carry_d = slice_sum[K];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(SLICES - 1)) begin
          s_d     = acc_upd;
          c_out_d = slice_sum[K] ^ op_q;
          if (op_q) begin
            ow_d = (x_q[N-1] != y_q[N-1]) && (acc_upd[N-1] != x_q[N-1]);
          end else begin
            ow_d = (x_q[N-1] == y_q[N-1]) && (acc_upd[N-1] != x_q[N-1]);
          end
          cnt_d   = '0;
          state_d = bus.soc ? DONE : IDLE;
        end
      end
      DONE: begin
        if (!bus.soc) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= 1'b0;
      carry_q <= 1'b0;
      acc_q   <= '0;
      s_q     <= '0;
      c_out_q <= 1'b0;
      ow_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      c_out_q <= c_out_d;
      ow_q    <= ow_d;
    end
  end

  assign bus.s     = s_q;
  assign bus.c_out = c_out_q;
  assign bus.ow    = ow_q;
  assign bus.eoc   = (state_q != RUN);

endmodule

// File: tb/tb_serial_addsub.sv
// Directed-vector bench for serial_addsub in three builds: 8/2, 8/8 and 16/4.
module tb_serial_addsub;
  logic clock = 1'b0;
  logic reset_ = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  serial_addsub_if #(.N(8))  i8  ();
  serial_addsub_if #(.N(8))  i88 ();
  serial_addsub_if #(.N(16)) i16 ();

  serial_addsub #(.N(8),  .K(2)) dut8  (.clock(clock), .reset_(reset_), .bus(i8));
  serial_addsub #(.N(8),  .K(8)) dut88 (.clock(clock), .reset_(reset_), .bus(i88));
  serial_addsub #(.N(16), .K(4)) dut16 (.clock(clock), .reset_(reset_), .bus(i16));

  // Drives one operation into the 8/2 build; returns at the negedge after acceptance.
  task automatic start8(input logic op, input logic [7:0] x, input logic [7:0] y,
                        input logic cin, input logic hold);
    @(negedge clock);
    i8.op = op; i8.x = x; i8.y = y; i8.c_in = cin; i8.soc = 1'b1;
    @(negedge clock);
    if (!hold) i8.soc = 1'b0;
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (i8.eoc === 1'b0 && cyc < 20) begin
      cyc++;
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    #1;
    checks++; if (i8.eoc !== 1'b1) begin errors++; $display("FAIL reset_eoc got %b exp 1", i8.eoc); end
    checks++; if (i8.s !== 8'h00) begin errors++; $display("FAIL reset_s got %h exp 00", i8.s); end
    checks++; if ({i8.c_out, i8.ow} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {i8.c_out, i8.ow}); end
    checks++; if (i16.s !== 16'h0000 || i16.eoc !== 1'b1) begin errors++; $display("FAIL reset_16 got s=%h eoc=%b exp 0000/1", i16.s, i16.eoc); end
    repeat (2) @(negedge clock);
    reset_ = 1'b1;
  endtask

  task automatic test_add_overflow;
    int cyc;
    start8(1'b0, 8'h7F, 8'h01, 1'b0, 1'b0);
    wait_done8(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL latency_8k2 got %0d exp 4", cyc); end
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h80, 1'b0, 1'b1}) begin errors++; $display("FAIL add_7f_01 got %h/%b/%b exp 80/0/1", i8.s, i8.c_out, i8.ow); end
  endtask

  task automatic test_add_carry_in;
    int cyc;
    start8(1'b0, 8'hFF, 8'h01, 1'b1, 1'b0);
    i8.x = 8'h00; i8.y = 8'h00; i8.c_in = 1'b0; i8.op = 1'b1;
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h01, 1'b1, 1'b0}) begin errors++; $display("FAIL add_ff_01_c got %h/%b/%b exp 01/1/0", i8.s, i8.c_out, i8.ow); end
    start8(1'b0, 8'h80, 8'h80, 1'b0, 1'b0);
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL add_80_80 got %h/%b/%b exp 00/1/1", i8.s, i8.c_out, i8.ow); end
  endtask

  task automatic test_subtract;
    int cyc;
    start8(1'b1, 8'h00, 8'h01, 1'b0, 1'b0);
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'hFF, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_00_01 got %h/%b/%b exp ff/1/0", i8.s, i8.c_out, i8.ow); end
    start8(1'b1, 8'h80, 8'h01, 1'b0, 1'b0);
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h7F, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_80_01 got %h/%b/%b exp 7f/0/1", i8.s, i8.c_out, i8.ow); end
    start8(1'b1, 8'h05, 8'h03, 1'b1, 1'b0);
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h01, 1'b0, 1'b0}) begin errors++; $display("FAIL sub_05_03_b got %h/%b/%b exp 01/0/0", i8.s, i8.c_out, i8.ow); end
  endtask

  task automatic test_soc_hold;
    int cyc;
    int bad;
    start8(1'b0, 8'h10, 8'h20, 1'b0, 1'b1);
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h30, 1'b0, 1'b0}) begin errors++; $display("FAIL hold_result got %h/%b/%b exp 30/0/0", i8.s, i8.c_out, i8.ow); end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i8.eoc !== 1'b1 || i8.s !== 8'h30) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL hold_no_restart got %0d bad cycles exp 0", bad); end
    i8.soc = 1'b0;
    start8(1'b0, 8'h55, 8'h55, 1'b0, 1'b0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (i8.eoc !== 1'b0 || i8.s !== 8'h30) bad++;
      @(negedge clock);
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL run_holds_old got %0d bad cycles exp 0", bad); end
    wait_done8(cyc);
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'hAA, 1'b0, 1'b1}) begin errors++; $display("FAIL restart_result got %h/%b/%b exp aa/0/1", i8.s, i8.c_out, i8.ow); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    start8(1'b0, 8'h01, 8'h01, 1'b0, 1'b0);
    @(negedge clock);
    reset_ = 1'b0;
    #1;
    checks++; if ({i8.eoc, i8.s, i8.c_out, i8.ow} !== {1'b1, 8'h00, 1'b0, 1'b0}) begin errors++; $display("FAIL abort_reset got eoc=%b s=%h c=%b ow=%b exp 1/00/0/0", i8.eoc, i8.s, i8.c_out, i8.ow); end
    @(negedge clock);
    reset_ = 1'b1;
    start8(1'b0, 8'h12, 8'h34, 1'b0, 1'b0);
    wait_done8(cyc);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL post_reset_latency got %0d exp 4", cyc); end
    checks++; if ({i8.s, i8.c_out, i8.ow} !== {8'h46, 1'b0, 1'b0}) begin errors++; $display("FAIL post_reset_add got %h/%b/%b exp 46/0/0", i8.s, i8.c_out, i8.ow); end
  endtask

  task automatic test_other_builds;
    int cyc;
    @(negedge clock);
    i88.op = 1'b0; i88.x = 8'h7F; i88.y = 8'h01; i88.c_in = 1'b0; i88.soc = 1'b1;
    @(negedge clock);
    i88.soc = 1'b0;
    cyc = 0;
    while (i88.eoc === 1'b0 && cyc < 20) begin cyc++; @(negedge clock); end
    checks++; if (cyc !== 1) begin errors++; $display("FAIL latency_8k8 got %0d exp 1", cyc); end
    checks++; if ({i88.s, i88.c_out, i88.ow} !== {8'h80, 1'b0, 1'b1}) begin errors++; $display("FAIL add_8k8 got %h/%b/%b exp 80/0/1", i88.s, i88.c_out, i88.ow); end
    i16.op = 1'b1; i16.x = 16'h8000; i16.y = 16'h0001; i16.c_in = 1'b0; i16.soc = 1'b1;
    @(negedge clock);
    i16.soc = 1'b0;
    cyc = 0;
    while (i16.eoc === 1'b0 && cyc < 20) begin cyc++; @(negedge clock); end
    checks++; if (cyc !== 4) begin errors++; $display("FAIL latency_16k4 got %0d exp 4", cyc); end
    checks++; if ({i16.s, i16.c_out, i16.ow} !== {16'h7FFF, 1'b0, 1'b1}) begin errors++; $display("FAIL sub_16k4 got %h/%b/%b exp 7fff/0/1", i16.s, i16.c_out, i16.ow); end
  endtask

  initial begin
    i8.soc = 1'b0;  i8.op = 1'b0;  i8.x = '0;  i8.y = '0;  i8.c_in = 1'b0;
    i88.soc = 1'b0; i88.op = 1'b0; i88.x = '0; i88.y = '0; i88.c_in = 1'b0;
    i16.soc = 1'b0; i16.op = 1'b0; i16.x = '0; i16.y = '0; i16.c_in = 1'b0;
    test_reset();
    test_add_overflow();
    test_add_carry_in();
    test_subtract();
    test_soc_hold();
    test_reset_mid_run();
    test_other_builds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
